// File: rtl/beat_lane_scroller.sv
// beat_lane_scroller: scrolling beat-note window with hit/miss judging, score and miss counters; define COMBO_TRACKING_EN to add combo/max_combo outputs
module beat_lane_scroller #(
    parameter int DEPTH      = 16,
    parameter int ROW_AW     = 4,
    parameter int SCORE_W    = 16,
    parameter int HIT_POINTS = 10
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               beat_tick,
    input  logic [7:0]         beat_data,
    input  logic               clear,
    input  logic [7:0]         keys,
    input  logic [ROW_AW-1:0]  rd_row,
    output logic [7:0]         rd_data,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         miss_count
`ifdef COMBO_TRACKING_EN
    ,
    output logic [7:0]         combo,
    output logic [7:0]         max_combo
`endif
);
    localparam int SW = SCORE_W + 8;
    logic [7:0] row [DEPTH];
    logic [7:0] keys_q, hits, outgoing, rd_next, miss_next;
    logic [3:0] n_hits, n_miss;
    logic [SW-1:0] score_sum;
    logic [SCORE_W-1:0] score_next;
    logic [8:0] miss_sum;
    always_comb begin
        hits = keys & ~keys_q & row[0];
        outgoing = beat_tick ? row[0] & ~hits : 8'h00;
        n_hits = 4'($countones(hits));
        n_miss = 4'($countones(outgoing));
        score_sum = SW'(score) + SW'(HIT_POINTS) * SW'(n_hits);
        score_next = score_sum > SW'({SCORE_W{1'b1}}) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
        miss_sum = 9'(miss_count) + 9'(n_miss);
        miss_next = miss_sum[8] ? 8'hFF : miss_sum[7:0];
        rd_next = 8'h00;
        for (int i = 0; i < DEPTH; i++)
            if (int'(rd_row) == i) rd_next = row[i];
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) row[i] <= 8'h00;
            keys_q <= 8'h00;
            rd_data <= 8'h00;
            hit_pulse <= 1'b0;
            miss_pulse <= 1'b0;
            score <= '0;
            miss_count <= 8'h00;
        end else begin
            keys_q <= keys;
            rd_data <= rd_next;
            if (clear) begin
                for (int i = 0; i < DEPTH; i++) row[i] <= 8'h00;
                hit_pulse <= 1'b0;
                miss_pulse <= 1'b0;
                score <= '0;
                miss_count <= 8'h00;
            end else begin
                hit_pulse <= |hits;
                miss_pulse <= |outgoing;
                score <= score_next;
                miss_count <= miss_next;
                if (beat_tick) begin
                    for (int i = 0; i < DEPTH - 1; i++) row[i] <= row[i+1];
                    row[DEPTH-1] <= beat_data;
                end else
                    row[0] <= row[0] & ~hits;
            end
        end
    end
`ifdef COMBO_TRACKING_EN
    logic [8:0] combo_sum;
    logic [7:0] combo_next;
    always_comb begin
        combo_sum = 9'(combo) + 9'(n_hits);
        combo_next = |outgoing ? 8'h00 : combo_sum[8] ? 8'hFF : combo_sum[7:0];
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            combo <= 8'h00;
            max_combo <= 8'h00;
        end else if (clear) begin
            combo <= 8'h00;
            max_combo <= 8'h00;
        end else begin
            combo <= combo_next;
            max_combo <= combo_next > max_combo ? combo_next : max_combo;
        end
    end
`endif
endmodule
